// File: rtl/iq_frame_packer_if.sv
// ============================================================================
// iq_frame_packer_if : AXI-Stream style sample input and framed output bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface iq_frame_packer_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] s_axis_tdata;
   logic              s_axis_tvalid;
   logic [DATA_W-1:0] m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic              m_axis_tlast;

   // master: the packer, which sources the framed stream
   modport master (
      input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
      output m_axis_tdata, m_axis_tvalid, m_axis_tlast
   );

   // slave: the environment that feeds samples and consumes frames
   modport slave (
      output s_axis_tdata, s_axis_tvalid, m_axis_tready,
      input  m_axis_tdata, m_axis_tvalid, m_axis_tlast
   );
endinterface

`default_nettype wire

// File: rtl/iq_frame_packer.sv
// ============================================================================
// iq_frame_packer : cuts a backpressure-free IQ stream into fixed-length frames
// Revision 1.0
// ============================================================================
`default_nettype none

module iq_frame_packer #(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 16
) (
   input  wire logic        aclk,
   input  wire logic        areset,
   input  wire logic        enable,
   input  wire logic [15:0] frame_len,
   output logic      [15:0] frame_count,
   output logic      [15:0] overflow_count,
   output logic             overflow,
   output logic             busy,
   iq_frame_packer_if.master axis
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_STOP = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [15:0]       r_len_q;
   logic [15:0]       r_push_cnt;
   logic [15:0]       w_push_cnt_next;
   logic [AW:0]       r_wr_ptr;
   logic [AW:0]       r_rd_ptr;
   logic [DATA_W:0]   r_mem [FIFO_DEPTH];
   logic [DATA_W:0]   w_head;
   logic              w_empty;
   logic              w_full;
   logic              w_pop;
   logic              w_active;
   logic              w_push;
   logic              w_drop;
   logic              w_last_push;

   assign w_empty  = (r_wr_ptr == r_rd_ptr);
   assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop    = !w_empty && axis.m_axis_tready;
   assign w_active = (r_state != S_IDLE);
   assign w_push   = w_active && axis.s_axis_tvalid && (!w_full || w_pop);
   assign w_drop   = w_active && axis.s_axis_tvalid && w_full && !w_pop;

   assign w_last_push     = (r_push_cnt == r_len_q - 16'd1);
   assign w_push_cnt_next = !w_push     ? r_push_cnt :
                            w_last_push ? 16'd0      : r_push_cnt + 16'd1;

   // Stopping looks at the post-push count so a frame closed this cycle is not reopened.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (enable) w_state_next = S_RUN;
         S_RUN:  if (!enable) w_state_next = (w_push_cnt_next != 16'd0) ? S_STOP : S_IDLE;
         S_STOP: begin
            if (enable)                    w_state_next = S_RUN;
            else if (w_push && w_last_push) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state        <= S_IDLE;
         r_len_q        <= 16'd1;
         r_push_cnt     <= 16'd0;
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         frame_count    <= 16'd0;
         overflow_count <= 16'd0;
         overflow       <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_push_cnt <= w_push_cnt_next;
         if (r_state == S_IDLE && enable)
            r_len_q <= (frame_len == 16'd0) ? 16'd1 : frame_len;
         if (w_push)
            r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         if (w_pop && w_head[DATA_W])
            frame_count <= frame_count + 16'd1;
         if (w_drop) begin
            overflow <= 1'b1;
            if (overflow_count != 16'hFFFF)
               overflow_count <= overflow_count + 16'd1;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (w_push)
         r_mem[r_wr_ptr[AW-1:0]] <= {w_last_push, axis.s_axis_tdata};
   end

   // Outputs are forced to zero when empty so stale storage never shows after reset.
   assign w_head             = r_mem[r_rd_ptr[AW-1:0]];
   assign axis.m_axis_tvalid = !w_empty;
   assign axis.m_axis_tdata  = w_empty ? '0 : w_head[DATA_W-1:0];
   assign axis.m_axis_tlast  = !w_empty && w_head[DATA_W];
   assign busy               = w_active || !w_empty;

endmodule

`default_nettype wire

// File: tb/tb_iq_frame_packer.sv
// ============================================================================
// tb_iq_frame_packer : scoreboard bench for the IQ frame packer
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_iq_frame_packer;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic        enable = 1'b0;
   logic [15:0] frame_len = 16'd1;
   logic [15:0] frame_count;
   logic [15:0] overflow_count;
   logic        overflow;
   logic        busy;

   int checks = 0;
   int failures = 0;

   logic [32:0] exp_q[$];
   logic [32:0] obs_q[$];

   iq_frame_packer_if #(.DATA_W(32)) axis ();

   iq_frame_packer #(.DATA_W(32), .FIFO_DEPTH(16)) dut (
      .aclk           (aclk),
      .areset         (areset),
      .enable         (enable),
      .frame_len      (frame_len),
      .frame_count    (frame_count),
      .overflow_count (overflow_count),
      .overflow       (overflow),
      .busy           (busy),
      .axis           (axis)
   );

   always #5 aclk = ~aclk;

   // accepted beats are recorded mid-cycle, ahead of the edge that consumes them
   always @(negedge aclk) begin
      if (!areset && axis.m_axis_tvalid && axis.m_axis_tready)
         obs_q.push_back({axis.m_axis_tlast, axis.m_axis_tdata});
   end

   function automatic logic [31:0] smp(input int i);
      return {16'(i + 16'h4000), 16'(i)};
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic send1(input logic [31:0] d);
      axis.s_axis_tvalid = 1'b1;
      axis.s_axis_tdata  = d;
      idle(1);
      axis.s_axis_tvalid = 1'b0;
   endtask

   task automatic do_reset();
      areset = 1'b1;
      enable = 1'b0;
      axis.s_axis_tvalid = 1'b0;
      axis.s_axis_tdata  = '0;
      axis.m_axis_tready = 1'b1;
      idle(3);
      areset = 1'b0;
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic wait_quiet(input bit need_idle, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (!axis.m_axis_tvalid && (!need_idle || !busy)) begin
            ok = 1'b1;
            break;
         end
         idle(1);
      end
      idle(2);
   endtask

   task automatic test_reset();
      areset = 1'b1;
      enable = 1'b0;
      axis.s_axis_tvalid = 1'b0;
      axis.s_axis_tdata  = '0;
      axis.m_axis_tready = 1'b1;
      idle(2);
      checks++; if (axis.m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid: got %b expected 0", axis.m_axis_tvalid); end
      checks++; if (axis.m_axis_tdata !== 32'd0) begin failures++; $display("FAIL rst_tdata: got %h expected 0", axis.m_axis_tdata); end
      checks++; if (axis.m_axis_tlast !== 1'b0) begin failures++; $display("FAIL rst_tlast: got %b expected 0", axis.m_axis_tlast); end
      checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL rst_frame_count: got %0d expected 0", frame_count); end
      checks++; if (overflow_count !== 16'd0) begin failures++; $display("FAIL rst_ovf_count: got %0d expected 0", overflow_count); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
      areset = 1'b0;
      idle(2);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy_after: got %b expected 0", busy); end
   endtask

   task automatic test_basic();
      bit ok;
      logic [32:0] e, o;
      do_reset();
      frame_len = 16'd4;
      enable = 1'b1;
      idle(2);
      for (int i = 1; i <= 12; i++) begin
         exp_q.push_back({(i % 4 == 0), smp(i)});
         send1(smp(i));
         idle(159);
      end
      wait_quiet(1'b0, ok);
      checks++; if (!ok) begin failures++; $display("FAIL basic_drain: timeout got 0 expected 1"); end
      checks++; if (frame_count !== 16'd3) begin failures++; $display("FAIL basic_frame_count: got %0d expected 3", frame_count); end
      checks++; if (overflow_count !== 16'd0) begin failures++; $display("FAIL basic_ovf_count: got %0d expected 0", overflow_count); end
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL basic_beats: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) begin failures++; $display("FAIL basic_beat: got %h expected %h", o, e); end
      end
      enable = 1'b0;
   endtask

   task automatic test_zero_len();
      bit ok;
      logic [32:0] e, o;
      do_reset();
      frame_len = 16'd0;
      enable = 1'b1;
      idle(2);
      for (int i = 1; i <= 3; i++) begin
         exp_q.push_back({1'b1, smp(i + 20)});
         send1(smp(i + 20));
         idle(4);
      end
      wait_quiet(1'b0, ok);
      checks++; if (!ok) begin failures++; $display("FAIL zero_drain: timeout got 0 expected 1"); end
      checks++; if (frame_count !== 16'd3) begin failures++; $display("FAIL zero_frame_count: got %0d expected 3", frame_count); end
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL zero_beats: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) begin failures++; $display("FAIL zero_beat: got %h expected %h", o, e); end
      end
      enable = 1'b0;
   endtask

   task automatic test_graceful_stop();
      bit ok;
      logic [32:0] e, o;
      do_reset();
      frame_len = 16'd8;
      enable = 1'b1;
      idle(2);
      for (int i = 1; i <= 9; i++) begin
         if (i == 4) begin
            enable = 1'b0;
            idle(3);
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stop_busy_in_stop: got %b expected 1", busy); end
         end
         if (i <= 8) exp_q.push_back({(i == 8), smp(i + 40)});
         send1(smp(i + 40));
         idle(3);
      end
      wait_quiet(1'b1, ok);
      checks++; if (!ok) begin failures++; $display("FAIL stop_busy_fall: timeout got 0 expected 1"); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL stop_overflow: got %b expected 0", overflow); end
      checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL stop_frame_count: got %0d expected 1", frame_count); end
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL stop_beats: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) begin failures++; $display("FAIL stop_beat: got %h expected %h", o, e); end
      end
   endtask

   task automatic test_overflow();
      bit ok;
      logic [32:0] e, o;
      do_reset();
      axis.m_axis_tready = 1'b0;
      frame_len = 16'd100;
      enable = 1'b1;
      idle(2);
      for (int i = 1; i <= 20; i++) begin
         if (i <= 16) exp_q.push_back({1'b0, smp(i)});
         axis.s_axis_tvalid = 1'b1;
         axis.s_axis_tdata  = smp(i);
         idle(1);
      end
      axis.s_axis_tvalid = 1'b0;
      idle(1);
      checks++; if (overflow_count !== 16'd4) begin failures++; $display("FAIL ovf_count: got %0d expected 4", overflow_count); end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
      checks++; if (axis.m_axis_tdata !== smp(1)) begin failures++; $display("FAIL ovf_head: got %h expected %h", axis.m_axis_tdata, smp(1)); end
      axis.m_axis_tready = 1'b1;
      idle(1);
      for (int i = 21; i <= 104; i++) begin
         exp_q.push_back({(i == 104), smp(i)});
         axis.s_axis_tvalid = 1'b1;
         axis.s_axis_tdata  = smp(i);
         idle(1);
      end
      axis.s_axis_tvalid = 1'b0;
      enable = 1'b0;
      wait_quiet(1'b1, ok);
      checks++; if (!ok) begin failures++; $display("FAIL ovf_drain: timeout got 0 expected 1"); end
      checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL ovf_frame_count: got %0d expected 1", frame_count); end
      checks++; if (overflow_count !== 16'd4) begin failures++; $display("FAIL ovf_count_final: got %0d expected 4", overflow_count); end
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL ovf_beats: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) begin failures++; $display("FAIL ovf_beat: got %h expected %h", o, e); end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [32:0] e, o, hold;
      do_reset();
      axis.m_axis_tready = 1'b0;
      frame_len = 16'd4;
      enable = 1'b1;
      idle(2);
      for (int i = 1; i <= 16; i++) begin
         exp_q.push_back({(i % 4 == 0), smp(i + 60)});
         axis.s_axis_tvalid = 1'b1;
         axis.s_axis_tdata  = smp(i + 60);
         idle(1);
      end
      axis.s_axis_tvalid = 1'b0;
      idle(1);
      for (int k = 17; k <= 32; k++) begin
         axis.m_axis_tready = 1'b0;
         axis.s_axis_tvalid = 1'b0;
         @(negedge aclk);
         hold = {axis.m_axis_tlast, axis.m_axis_tdata};
         idle(1);
         axis.m_axis_tready = 1'b1;
         axis.s_axis_tvalid = 1'b1;
         axis.s_axis_tdata  = smp(k + 60);
         exp_q.push_back({(k % 4 == 0), smp(k + 60)});
         @(negedge aclk);
         checks++; if ({axis.m_axis_tlast, axis.m_axis_tdata} !== hold) begin failures++; $display("FAIL bp_stable: got %h expected %h", {axis.m_axis_tlast, axis.m_axis_tdata}, hold); end
         idle(1);
      end
      axis.s_axis_tvalid = 1'b0;
      axis.m_axis_tready = 1'b1;
      enable = 1'b0;
      wait_quiet(1'b1, ok);
      checks++; if (!ok) begin failures++; $display("FAIL bp_drain: timeout got 0 expected 1"); end
      checks++; if (overflow_count !== 16'd0) begin failures++; $display("FAIL bp_ovf_count: got %0d expected 0", overflow_count); end
      checks++; if (frame_count !== 16'd8) begin failures++; $display("FAIL bp_frame_count: got %0d expected 8", frame_count); end
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL bp_beats: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) begin failures++; $display("FAIL bp_beat: got %h expected %h", o, e); end
      end
   endtask

   task automatic test_reset_midframe();
      bit ok;
      logic [32:0] e, o;
      do_reset();
      axis.m_axis_tready = 1'b0;
      frame_len = 16'd4;
      enable = 1'b1;
      idle(2);
      send1(smp(80));
      idle(1);
      send1(smp(81));
      idle(1);
      checks++; if (axis.m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL mid_prefill: got %b expected 1", axis.m_axis_tvalid); end
      areset = 1'b1;
      #1;
      checks++; if (axis.m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL mid_tvalid: got %b expected 0", axis.m_axis_tvalid); end
      checks++; if (axis.m_axis_tdata !== 32'd0) begin failures++; $display("FAIL mid_tdata: got %h expected 0", axis.m_axis_tdata); end
      checks++; if (axis.m_axis_tlast !== 1'b0) begin failures++; $display("FAIL mid_tlast: got %b expected 0", axis.m_axis_tlast); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %b expected 0", busy); end
      idle(2);
      areset = 1'b0;
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL mid_leak: got %0d beats expected 0", obs_q.size()); end
      obs_q.delete();
      axis.m_axis_tready = 1'b1;
      idle(2);
      checks++; if (axis.m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL mid_empty: got %b expected 0", axis.m_axis_tvalid); end
      for (int i = 1; i <= 4; i++) begin
         exp_q.push_back({(i == 4), smp(i + 90)});
         send1(smp(i + 90));
         idle(2);
      end
      enable = 1'b0;
      wait_quiet(1'b1, ok);
      checks++; if (!ok) begin failures++; $display("FAIL mid_drain: timeout got 0 expected 1"); end
      checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL mid_frame_count: got %0d expected 1", frame_count); end
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL mid_beats: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) begin failures++; $display("FAIL mid_beat: got %h expected %h", o, e); end
      end
   endtask

   initial begin
      axis.s_axis_tvalid = 1'b0;
      axis.s_axis_tdata  = '0;
      axis.m_axis_tready = 1'b1;
      test_reset();
      test_basic();
      test_zero_len();
      test_graceful_stop();
      test_overflow();
      test_backpressure();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/iq_frame_packer.md
IQ_FRAME_PACKER -- requirements
Module: iq_frame_packer

Interface
REQ-001 Parameter DATA_W, default 32: IQ sample width, I in [15:0], Q in [31:16].
REQ-002 Parameter FIFO_DEPTH, default 16: sample FIFO depth; SHALL be a power of two and at least 4.
REQ-003 aclk  in  1  sole clock; all logic is clocked on the rising edge.
REQ-004 areset  in  1  asynchronous, active-high reset.
REQ-005 s_axis_tdata  in  DATA_W  decimated IQ sample from the DDC output.
REQ-006 s_axis_tvalid  in  1  sample strobe; the upstream stage has no backpressure and there is no s_axis_tready.
REQ-007 enable  in  1  level request to capture frames.
REQ-008 frame_len  in  16  samples per frame; 0 is treated as 1.
REQ-009 m_axis_tdata  out  DATA_W  framed IQ sample.
REQ-010 m_axis_tvalid  out  1  output sample valid.
REQ-011 m_axis_tready  in  1  downstream accept.
REQ-012 m_axis_tlast  out  1  last sample of a frame.
REQ-013 frame_count  out  16  completed output frames; wraps.
REQ-014 overflow_count  out  16  dropped samples; saturates at 0xFFFF.
REQ-015 overflow  out  1  sticky flag, set on any drop.
REQ-016 busy  out  1  high when the state is not IDLE or the FIFO is not empty.

Function
REQ-017 Push-side FSM states: IDLE, RUN, STOP.
- IDLE: input is discarded without being counted as overflow.
- RUN: samples are pushed into the FIFO.
- STOP: samples are pushed until the current frame completes.
REQ-018 IDLE->RUN occurs on the first cycle with enable=1. frame_len is latched (0->1) into len_q on that transition only.
REQ-019 RUN->STOP occurs when enable=0 and push_cnt!=0. RUN->IDLE occurs directly when enable=0 and push_cnt==0.
REQ-020 STOP->IDLE occurs on the push that completes the frame. Re-asserting enable in STOP returns the FSM to RUN and keeps len_q unchanged.
REQ-021 push_cnt counts pushed samples from 0 to len_q-1 and wraps to 0 after len_q-1. Each pushed word stores the flag last=(push_cnt==len_q-1) alongside the data, so the FIFO is DATA_W+1 bits wide.
REQ-022 A push occurs when the state is RUN or STOP, s_axis_tvalid=1, and the FIFO is not full, or it is full with a pop in the same cycle.
REQ-023 When the state is RUN or STOP, s_axis_tvalid=1, and the FIFO is full with no pop:
- the sample is dropped;
- push_cnt does not advance;
- overflow_count increments, saturating;
- overflow is set.
REQ-024 The FIFO is registered with no bypass. A sample pushed in cycle N is visible on m_axis_tvalid/tdata no earlier than cycle N+1.
REQ-025 A pop occurs when m_axis_tvalid && m_axis_tready. m_axis_tdata, m_axis_tlast and m_axis_tvalid SHALL remain stable while tvalid=1 and tready=0.
REQ-026 m_axis_tlast equals the stored last flag of the head word. frame_count increments on each pop with tlast=1 and wraps from 0xFFFF to 0.
REQ-027 A push into an empty FIFO while a pop is not possible sets the FIFO to non-empty.
REQ-028 A push and a pop in the same cycle leave the occupancy unchanged. Occupancy SHALL never exceed FIFO_DEPTH or underflow.
REQ-029 The pointers are log2(FIFO_DEPTH)+1 bits wide, and full/empty are decided from the MSB comparison.
REQ-030 A frame is delivered downstream with exactly len_q beats, except when samples are dropped. A drop does not alter frame length; the frame completes with later samples.
REQ-031 The FIFO continues to drain in IDLE. busy falls only when the state is IDLE and the FIFO is empty.

Reset
REQ-032 While areset=1:
- state=IDLE;
- push_cnt=0;
- len_q=1;
- FIFO pointers=0;
- m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0;
- frame_count=0, overflow_count=0, overflow=0, busy=0.
REQ-033 Reset asserted mid-frame discards FIFO contents immediately, with no partial frame emitted after release.
REQ-034 After areset deasserts, the first push is possible on the second rising edge of aclk.

Verification
REQ-035 Basic framing: frame_len=4, enable=1, tready=1, 12 samples 1..12 at one per 160 cycles -> three frames, tlast on samples 4, 8 and 12, frame_count=3, overflow_count=0.
REQ-036 Zero length: frame_len=0, 3 samples -> every beat has tlast=1, frame_count=3.
REQ-037 Graceful stop: frame_len=8, enable dropped after sample 3 -> samples 4..8 are still captured, tlast on sample 8, then IDLE; sample 9 is discarded, overflow=0, busy falls once the FIFO is empty.
REQ-038 Overflow: FIFO_DEPTH=16, frame_len=100, tready=0, 20 back-to-back samples ->
- 16 samples are stored, overflow_count=4, overflow=1;
- after tready=1 and a further 84 samples, tlast appears on the 100th delivered beat.
REQ-039 Backpressure: tready toggled every cycle during a full-FIFO sample push/pop -> tdata/tlast remain stable while stalled, with no loss and no duplication.
REQ-040 Reset mid-frame: areset pulsed after 2 of 4 samples -> all outputs are 0, the FIFO is empty, and the next frame starts with a sample carrying push_cnt=0.
